// File: rtl/morra_cinese.sv
// Rock-paper-scissors referee: per-round verdict plus match tracking.
// Optional no-repeat-winning-move rule: MORRA_CINESE_REPEAT_RULE_EN.
module morra_cinese (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] PRIMO,
  input  logic [1:0] SECONDO,
  input  logic       INIZIA,
  output logic [1:0] MANCHE,
  output logic [1:0] PARTITA
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_DONE
  } state_t;

  state_t     r_state, w_state_nx;
  logic [4:0] r_max, w_max_nx;
  logic [4:0] r_played, w_played_nx;
  logic [4:0] r_w1, w_w1_nx;
  logic [4:0] r_w2, w_w2_nx;
  logic [1:0] r_manche, w_manche_nx;
  logic [1:0] r_partita, w_partita_nx;

  logic       w_draw;
  logic       w_p1win;
  logic       w_blocked;
  logic       w_valid;
  logic       w_lead1;
  logic       w_lead2;

  assign w_draw  = (PRIMO == SECONDO);
  assign w_p1win = (PRIMO == 2'b01 && SECONDO == 2'b11) ||
                   (PRIMO == 2'b10 && SECONDO == 2'b01) ||
                   (PRIMO == 2'b11 && SECONDO == 2'b10);

`ifdef MORRA_CINESE_REPEAT_RULE_EN
  // Last decided round: winner id (01/10, 00 none) and its move.
  logic [1:0] r_rwin, w_rwin_nx;
  logic [1:0] r_rmove, w_rmove_nx;

  assign w_blocked = (r_rwin == 2'b01 && PRIMO == r_rmove) ||
                     (r_rwin == 2'b10 && SECONDO == r_rmove);
`else
  assign w_blocked = 1'b0;
`endif

  assign w_valid = (PRIMO != 2'b00) && (SECONDO != 2'b00) && !w_blocked;
  assign w_lead1 = (w_w1_nx >= w_w2_nx + 5'd2);
  assign w_lead2 = (w_w2_nx >= w_w1_nx + 5'd2);

  always_comb begin
    w_state_nx   = r_state;
    w_max_nx     = r_max;
    w_played_nx  = r_played;
    w_w1_nx      = r_w1;
    w_w2_nx      = r_w2;
    w_manche_nx  = 2'b00;
    w_partita_nx = 2'b00;
`ifdef MORRA_CINESE_REPEAT_RULE_EN
    w_rwin_nx    = r_rwin;
    w_rmove_nx   = r_rmove;
`endif
    if (INIZIA) begin
      w_state_nx  = S_PLAY;
      w_max_nx    = 5'd4 + {1'b0, PRIMO, SECONDO};
      w_played_nx = 5'd0;
      w_w1_nx     = 5'd0;
      w_w2_nx     = 5'd0;
`ifdef MORRA_CINESE_REPEAT_RULE_EN
      w_rwin_nx   = 2'b00;
      w_rmove_nx  = 2'b00;
`endif
    end else if (r_state == S_PLAY && w_valid) begin
      w_played_nx = r_played + 5'd1;
      unique case (1'b1)
        w_draw: begin
          w_manche_nx = 2'b11;
`ifdef MORRA_CINESE_REPEAT_RULE_EN
          w_rwin_nx   = 2'b00;
`endif
        end
        w_p1win: begin
          w_manche_nx = 2'b01;
          w_w1_nx     = r_w1 + 5'd1;
`ifdef MORRA_CINESE_REPEAT_RULE_EN
          w_rwin_nx   = 2'b01;
          w_rmove_nx  = PRIMO;
`endif
        end
        default: begin
          w_manche_nx = 2'b10;
          w_w2_nx     = r_w2 + 5'd1;
`ifdef MORRA_CINESE_REPEAT_RULE_EN
          w_rwin_nx   = 2'b10;
          w_rmove_nx  = SECONDO;
`endif
        end
      endcase
      // Early decision by a two-win margin beats the length limit.
      if (w_played_nx >= 5'd4 && w_lead1) begin
        w_partita_nx = 2'b01;
      end else if (w_played_nx >= 5'd4 && w_lead2) begin
        w_partita_nx = 2'b10;
      end else if (w_played_nx == r_max) begin
        if (w_w1_nx > w_w2_nx)      w_partita_nx = 2'b01;
        else if (w_w2_nx > w_w1_nx) w_partita_nx = 2'b10;
        else                        w_partita_nx = 2'b11;
      end
      if (w_partita_nx != 2'b00) w_state_nx = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_max     <= 5'd0;
      r_played  <= 5'd0;
      r_w1      <= 5'd0;
      r_w2      <= 5'd0;
      r_manche  <= 2'b00;
      r_partita <= 2'b00;
`ifdef MORRA_CINESE_REPEAT_RULE_EN
      r_rwin    <= 2'b00;
      r_rmove   <= 2'b00;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_max     <= w_max_nx;
      r_played  <= w_played_nx;
      r_w1      <= w_w1_nx;
      r_w2      <= w_w2_nx;
      r_manche  <= w_manche_nx;
      r_partita <= w_partita_nx;
`ifdef MORRA_CINESE_REPEAT_RULE_EN
      r_rwin    <= w_rwin_nx;
      r_rmove   <= w_rmove_nx;
`endif
    end
  end

  assign MANCHE  = r_manche;
  assign PARTITA = r_partita;

endmodule

// File: tb/tb_morra_cinese.sv
// Bench for morra_cinese: directed plan steps plus random play
// against a rules-level match model.
module tb_morra_cinese;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] PRIMO = 2'b00;
  logic [1:0] SECONDO = 2'b00;
  logic       INIZIA = 1'b0;
  logic [1:0] MANCHE;
  logic [1:0] PARTITA;

  int errors = 0;
  int checks = 0;

  // Match model: 0 idle, 1 playing, 2 finished
  int m_mode = 0;
  int m_max = 0;
  int m_played = 0;
  int m_w1 = 0;
  int m_w2 = 0;
  int m_lastwin = 0;
  int m_lastmove = 0;

  morra_cinese dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .PRIMO   (PRIMO),
    .SECONDO (SECONDO),
    .INIZIA  (INIZIA),
    .MANCHE  (MANCHE),
    .PARTITA (PARTITA)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // 0 draw, 1 first player wins, 2 second player wins (1 rock,2 paper,3 scissors)
  function automatic int rps(input int a, input int b);
    if (a == b) return 0;
    return ((a - b + 3) % 3 == 1) ? 1 : 2;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_max = 0; m_played = 0;
    m_w1 = 0; m_w2 = 0; m_lastwin = 0; m_lastmove = 0;
  endtask

  task automatic model(input int p, input int s, input bit ini,
                       output logic [1:0] em, output logic [1:0] ep);
    bit rep;
    int r;
    em = 2'd0;
    ep = 2'd0;
    rep = 1'b0;
`ifdef MORRA_CINESE_REPEAT_RULE_EN
    rep = (m_lastwin == 1 && p == m_lastmove) ||
          (m_lastwin == 2 && s == m_lastmove);
`endif
    if (ini) begin
      m_mode = 1; m_max = 4 + p * 4 + s;
      m_played = 0; m_w1 = 0; m_w2 = 0; m_lastwin = 0;
    end else if (m_mode == 1 && p != 0 && s != 0 && !rep) begin
      r = rps(p, s);
      m_played++;
      if (r == 1) m_w1++;
      if (r == 2) m_w2++;
      em = (r == 0) ? 2'd3 : 2'(r);
      m_lastwin = r;
      m_lastmove = (r == 1) ? p : s;
      if (m_played >= 4 && (m_w1 - m_w2 >= 2 || m_w2 - m_w1 >= 2))
        ep = (m_w1 > m_w2) ? 2'd1 : 2'd2;
      else if (m_played == m_max)
        ep = (m_w1 > m_w2) ? 2'd1 : (m_w2 > m_w1) ? 2'd2 : 2'd3;
      if (ep != 0) m_mode = 2;
    end
  endtask

  // Inputs applied 1 time unit after a rising edge, outputs checked 1 after the next.
  task automatic step(input logic [1:0] p, input logic [1:0] s,
                      input logic ini, input int xm = -1, input int xp = -1);
    logic [1:0] em, ep;
    PRIMO = p; SECONDO = s; INIZIA = ini;
    model(int'(p), int'(s), ini, em, ep);
    @(posedge clk);
    #1;
    check("manche", MANCHE, em);
    check("partita", PARTITA, ep);
    if (xm >= 0) check("manche_plan", MANCHE, 2'(xm));
    if (xp >= 0) check("partita_plan", PARTITA, 2'(xp));
  endtask

  initial begin
    logic [1:0] rp, rs;
    logic ri;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_manche", MANCHE, 2'd0);
    check("reset_partita", PARTITA, 2'd0);
    rst_n = 1'b1;

    // Idle ignores play
    step(2'b01, 2'b11, 1'b0, 0, 0);

    // MAX=4 match: P1 wins 2-1 at the limit
    step(2'b00, 2'b00, 1'b1, 0, 0);
    step(2'b01, 2'b11, 1'b0, 1, 0);
    step(2'b10, 2'b11, 1'b0, 2, 0);
    step(2'b01, 2'b01, 1'b0, 3, 0);
    step(2'b10, 2'b01, 1'b0, 1, 1);
    step(2'b01, 2'b11, 1'b0, 0, 0);

    // Repeat of winning move
    step(2'b00, 2'b00, 1'b1, 0, 0);
    step(2'b01, 2'b11, 1'b0, 1, 0);
`ifdef MORRA_CINESE_REPEAT_RULE_EN
    step(2'b01, 2'b10, 1'b0, 0, 0);
`else
    step(2'b01, 2'b10, 1'b0, 2, 0);
`endif

    // P2 sweeps four rounds
    step(2'b00, 2'b00, 1'b1, 0, 0);
    step(2'b11, 2'b01, 1'b0, 2, 0);
    step(2'b10, 2'b11, 1'b0, 2, 0);
    step(2'b01, 2'b10, 1'b0, 2, 0);
    step(2'b11, 2'b01, 1'b0, 2, 2);
    step(2'b10, 2'b11, 1'b0, 0, 0);
    step(2'b01, 2'b10, 1'b0, 0, 0);

    // MAX=14, all draws
    step(2'b10, 2'b10, 1'b1, 0, 0);
    for (int i = 0; i < 13; i++) step(2'b10, 2'b10, 1'b0, 3, 0);
    step(2'b10, 2'b10, 1'b0, 3, 3);

    // Asynchronous reset mid-match
    step(2'b00, 2'b00, 1'b1, 0, 0);
    step(2'b01, 2'b11, 1'b0, 1, 0);
    rst_n = 1'b0;
    #2;
    check("async_manche", MANCHE, 2'd0);
    check("async_partita", PARTITA, 2'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    step(2'b01, 2'b11, 1'b0, 0, 0);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      ri = ($urandom_range(0, 24) == 0);
      rp = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      rs = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      if (ri) rp = 2'($urandom_range(0, 3));
      if (ri) rs = 2'($urandom_range(0, 3));
      step(rp, rs, ri);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morra_cinese.md
# morra_cinese

Rock-paper-scissors ("morra cinese") referee FSMD for two players. It samples one move per player each clock and classifies every round ("manche") as P1 win, P2 win, draw or invalid. It also tracks the match ("partita") and declares its outcome. It sits between the player-input logic and the score/display logic.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `PRIMO`  in  2  player-1 move: 00 none, 01 rock, 10 paper, 11 scissors. While `INIZIA`=1 it is the high half of the match-length code.
- `SECONDO`  in  2  player-2 move, same encoding. While `INIZIA`=1 it is the low half of the match-length code.
- `INIZIA`  in  1  start/restart a match this cycle.
- `MANCHE`  out  2  registered round result: 00 invalid/no round, 01 P1 won, 10 P2 won, 11 draw.
- `PARTITA`  out  2  registered match result: 00 not finished, 01 P1 won, 10 P2 won, 11 draw.

## Operation
- States: IDLE (reset), PLAY, DONE.
- `INIZIA`=1 in any state has priority:
  - Load MAX = 4 + {PRIMO,SECONDO} (5 bits, range 4..19).
  - Clear the played count PLAYED, the win counters W1 and W2, and the repeat restriction.
  - Go to PLAY. Outputs for that edge are `MANCHE`=00, `PARTITA`=00.
- IDLE and DONE with `INIZIA`=0: inputs ignored; `MANCHE`=00, `PARTITA`=00. Stay in state.
- PLAY with `INIZIA`=0, round validity:
  - Invalid if either move is 00.
  - Invalid if the winner of the last decided round replays that winning move.
  - An invalid round gives `MANCHE`=00 and changes no counter or restriction.
- Valid round results:
  - Rock beats scissors, scissors beats paper, paper beats rock. Equal moves are a draw.
  - PLAYED is incremented. W1 or W2 is incremented on a win.
  - A win records (winner, winning move) as the restriction.
  - A draw clears the restriction.
- End check after each valid round, using updated counts:
  - If PLAYED ≥ 4 and |W1−W2| ≥ 2, the leader wins.
  - Otherwise, if PLAYED = MAX, the player with more wins takes the match; equal wins is a draw (11).
  - On end: `PARTITA` is set together with that round's `MANCHE`, and the state goes to DONE.
- `PARTITA` is nonzero only on the cycle following the ending edge. It returns to 00 on the next edge.
- Counters are 5 bits; PLAYED never exceeds MAX, so there is no wrap.

## Timing
- Inputs are sampled on the rising edge of `clk`. Outputs update on the same edge: one-cycle latency, then held for one cycle.
- Exactly one round is evaluated per clock; there is no handshake.
- `rst_n` low: immediately force IDLE, all counters 0, restriction cleared, `MANCHE`=00, `PARTITA`=00. Reset mid-match aborts the match.
- `INIZIA` asserted mid-match aborts the match with no `PARTITA` report.

## Configuration
- `MORRA_CINESE_REPEAT_RULE_EN`
  - Defined: the no-repeat-winning-move rule applies as above.
  - Undefined: the restriction logic is omitted, and any pair of non-00 moves is a valid round.

## Test plan
- Reset, then moves 01/11 with `INIZIA`=0 → `MANCHE`=00, `PARTITA`=00 (IDLE ignores play).
- `INIZIA`=1 with 00/00 (MAX=4), then rounds 01/11, 10/11, 01/01, 10/01 → `MANCHE` 01,10,11,01; end at round 4 with W1=2, W2=1 → `PARTITA`=01.
- With the macro defined, after P1 wins with 01 vs 11, next round 01/10 → `MANCHE`=00 and PLAYED unchanged. With the macro undefined, the same round → `MANCHE`=10.
- `INIZIA`=1 with 00/00, then P2 wins 4 rounds in a row using alternating moves (11/01, 10/11, 01/10, 11/01) → `PARTITA`=10 after round 4. The next edge → `PARTITA`=00, and further moves give `MANCHE`=00.
- `INIZIA`=1 with 10/10 (MAX=14), then 14 draws 10/10 → `PARTITA`=11 after round 14, and 00 on every earlier round.
- `rst_n` pulsed low between clock edges mid-match → outputs 00 immediately. A following move without `INIZIA` is ignored.
